mem_arbiter: RTL

Two-requester arbiter sharing the single cache-refill memory port between the instruction-cache controller (line reads) and the data-cache controller (line reads and dirty-line writebacks). Sits between both cache FSMs and the memory/bus bridge. Grants whole-line transactions using round-robin priority. Forwards read beats to the owner and serialises writeback lines into word beats.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_rr_arbiter2.sv | 38 +++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the cache-refill memory arbiter: FSM state encodings and
// the transaction-owner tag used by both the arbiter core and the top level.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_ADDR  = 3'd1,
    ARB_RDATA = 3'd2,
    ARB_WDATA = 3'd3,
    ARB_WRESP = 3'd4
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LINE_WORDS = 4;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin winner selection between the I-side and D-side
// requesters, with the last-grant history register.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic d_valid,
  input  logic grant_en,
  output logic winner_d,
  output logic any_valid
);
  import mem_arbiter_pkg::*;

  owner_t last_grant;
  owner_t winner;

  // On a tie the side that was not granted last wins.
  always_comb begin
    winner = OWN_I;
    if (i_valid && d_valid) begin
      winner = (last_grant == OWN_D) ? OWN_I : OWN_D;
    end else if (d_valid) begin
      winner = OWN_D;
    end
  end

  assign any_valid = i_valid | d_valid;
  assign winner_d  = (winner == OWN_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= OWN_D;
    end else if (grant_en && any_valid) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates whole-line transactions from the I-cache and D-cache controllers
// onto the shared refill port; forwards read beats, serialises writebacks.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_req_valid,
  input  logic [ADDR_W-1:0]            i_req_addr,
  output logic                         i_req_ready,
  output logic [DATA_W-1:0]            i_rdata,
  output logic                         i_rvalid,
  output logic                         i_rlast,
  input  logic                         d_req_valid,
  input  logic                         d_req_we,
  input  logic [ADDR_W-1:0]            d_req_addr,
  input  logic [DATA_W*LINE_WORDS-1:0] d_req_wdata,
  output logic                         d_req_ready,
  output logic [DATA_W-1:0]            d_rdata,
  output logic                         d_rvalid,
  output logic                         d_rlast,
  output logic                         d_wdone,
  output logic                         mem_req_valid,
  output logic                         mem_req_we,
  output logic [ADDR_W-1:0]            mem_req_addr,
  input  logic                         mem_req_ready,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic                         mem_wvalid,
  output logic                         mem_wlast,
  input  logic                         mem_wready,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_rvalid,
  input  logic                         mem_rlast,
  input  logic                         mem_bvalid
);
  import mem_arbiter_pkg::*;

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

  arb_state_t                  state, state_nxt;
  owner_t                      owner;
  logic                        we;
  logic [ADDR_W-1:0]           addr;
  logic [DATA_W*LINE_WORDS-1:0] line;
  logic [CNT_W-1:0]            cnt;
  logic                        wdone;
  logic                        winner_d;
  logic                        any_valid;
  logic                        grant;
  logic                        last_beat;
  logic [DATA_W-1:0]           cur_word;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_req_valid),
    .d_valid   (d_req_valid),
    .grant_en  (state == ARB_IDLE),
    .winner_d  (winner_d),
    .any_valid (any_valid)
  );

  assign grant     = (state == ARB_IDLE) && any_valid;
  assign last_beat = (cnt == LAST_IDX);
  assign cur_word  = line[int'(cnt)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (any_valid) state_nxt = ARB_ADDR;
      ARB_ADDR:  if (mem_req_ready) state_nxt = we ? ARB_WDATA : ARB_RDATA;
      ARB_RDATA: if (mem_rvalid && mem_rlast) state_nxt = ARB_IDLE;
      ARB_WDATA: if (mem_wready && last_beat) state_nxt = ARB_WRESP;
      ARB_WRESP: if (mem_bvalid) state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  // Control registers: owner, type, beat counter and the registered ack pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= OWN_I;
      we    <= 1'b0;
      cnt   <= '0;
      wdone <= 1'b0;
    end else begin
      wdone <= (state == ARB_WRESP) && mem_bvalid;
      if (grant) begin
        owner <= owner_t'(winner_d);
        we    <= winner_d & d_req_we;
      end
      if (state == ARB_ADDR && mem_req_ready) begin
        cnt <= '0;
      end else if (state == ARB_WDATA && mem_wready) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Address and line buffer are pure data; outputs are gated by state.
  always_ff @(posedge clk) begin
    if (grant) begin
      addr <= winner_d ? d_req_addr : i_req_addr;
      line <= d_req_wdata;
    end
  end

  assign mem_req_valid = (state == ARB_ADDR);
  assign mem_req_we    = (state == ARB_ADDR) && we;
  assign mem_req_addr  = (state == ARB_ADDR) ? addr : '0;

  assign i_req_ready = (state == ARB_ADDR) && (owner == OWN_I) && mem_req_ready;
  assign d_req_ready = (state == ARB_ADDR) && (owner == OWN_D) && mem_req_ready;

  assign i_rvalid = (state == ARB_RDATA) && (owner == OWN_I) && mem_rvalid;
  assign i_rlast  = i_rvalid && mem_rlast;
  assign i_rdata  = ((state == ARB_RDATA) && (owner == OWN_I)) ? mem_rdata : '0;
  assign d_rvalid = (state == ARB_RDATA) && (owner == OWN_D) && mem_rvalid;
  assign d_rlast  = d_rvalid && mem_rlast;
  assign d_rdata  = ((state == ARB_RDATA) && (owner == OWN_D)) ? mem_rdata : '0;

  assign mem_wvalid = (state == ARB_WDATA);
  assign mem_wlast  = (state == ARB_WDATA) && last_beat;
  assign mem_wdata  = (state == ARB_WDATA) ? cur_word : '0;

  assign d_wdone = wdone;

endmodule
